// File: rtl/bu_pipe_mq.sv
// bu_pipe_mq: 3-stage multi-lane CT/GS modular butterfly with global-stall valid/ready flow
module bu_pipe_mq #(
  parameter int DATA_WIDTH = 32,
  parameter int VAL_Q = 8380417,
  parameter int NUM_LANES = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [1:0]                      mode_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data1_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data2_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] zeta_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data1_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data2_o,
  output logic                            busy_o
);
  localparam int DW = DATA_WIDTH;
  localparam int K = $clog2(VAL_Q);
  localparam logic [DW-1:0] Q = DW'(VAL_Q);
  localparam logic [DW:0] QX = (DW+1)'(VAL_Q);
  localparam logic [K:0] MU = (K+1)'((128'd1 << (2*K)) / 128'(VAL_Q));
  function automatic logic [DW-1:0] add_q(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s >= QX ? DW'(s - QX) : DW'(s);
  endfunction
  function automatic logic [DW-1:0] sub_q(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x >= y ? x - y : x + Q - y;
  endfunction
  function automatic logic [DW-1:0] half_q(input logic [DW-1:0] x);
    return x[0] ? DW'(({1'b0, x} + QX) >> 1) : x >> 1;
  endfunction
  logic [2:0] v;
  logic [1:0] m1, m2;
  logic stall, gs0, gs2, half2;
  assign stall = v[2] & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign out_valid_o = v[2];
  assign busy_o = |v;
  assign gs0 = mode_i == 2'b01 || mode_i == 2'b10;
  assign gs2 = m2 == 2'b01 || m2 == 2'b10;
  assign half2 = m2 == 2'b10;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) v <= '0;
    else if (!stall) v <= {v[1:0], in_valid_i};
  end
  always_ff @(posedge clk_i) begin
    if (!stall) begin
      m1 <= mode_i;
      m2 <= m1;
    end
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DW-1:0] a, b, w, s0, mop, a1, s1, a2, s2, r2, o1, o2, ap, bp;
    logic [2*K-1:0] p1, qq;
    logic [K:0] qe;
    logic [DW:0] r0, ra, rb;
    assign a = data1_i[i*DW +: DW];
    assign b = data2_i[i*DW +: DW];
    assign w = zeta_i[i*DW +: DW];
    assign s0 = add_q(a, b);
    assign mop = gs0 ? sub_q(a, b) : b;
    // Barrett: quotient estimate is at most 2 short, so two trial subtractions make it exact
    assign qe = (K+1)'(((3*K+1)'(p1) * (3*K+1)'(MU)) >> (2*K));
    assign qq = (2*K)'(qe) * (2*K)'(Q);
    assign r0 = (DW+1)'(p1 - qq);
    assign ra = r0 >= QX ? r0 - QX : r0;
    assign rb = ra >= QX ? ra - QX : ra;
    assign ap = gs2 ? s2 : add_q(a2, r2);
    assign bp = gs2 ? r2 : sub_q(a2, r2);
    always_ff @(posedge clk_i) begin
      if (!stall) begin
        a1 <= a;
        s1 <= s0;
        p1 <= (2*K)'((2*DW)'(w) * (2*DW)'(mop));
        a2 <= a1;
        s2 <= s1;
        r2 <= DW'(rb);
        o1 <= half2 ? half_q(ap) : ap;
        o2 <= half2 ? half_q(bp) : bp;
      end
    end
    assign data1_o[i*DW +: DW] = v[2] ? o1 : '0;
    assign data2_o[i*DW +: DW] = v[2] ? o2 : '0;
  end
endmodule

// File: tb/tb_bu_pipe_mq.sv
// tb_bu_pipe_mq: directed vectors, stalled random stream and reset/idle checks for bu_pipe_mq
module tb_bu_pipe_mq;
  localparam longint unsigned Q = 8380417;
  logic clk_i = 0, reset_ni = 1, in_valid_i = 0, out_ready_i = 1;
  logic [1:0] mode_i = 0;
  logic [63:0] data1_i = 0, data2_i = 0, zeta_i = 0;
  logic in_ready_o, out_valid_o, busy_o;
  logic [63:0] data1_o, data2_o;
  int n_vec = 0, n_err = 0, got_n = 0;
  logic [127:0] exq[$];

  bu_pipe_mq dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mode_i(mode_i), .data1_i(data1_i), .data2_i(data2_i), .zeta_i(zeta_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data1_o(data1_o),
    .data2_o(data2_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] gold_lane(input logic [1:0] m, input longint unsigned a,
                                            input longint unsigned b, input longint unsigned w);
    longint unsigned t, x, y;
    if (m == 2'd1 || m == 2'd2) begin
      x = (a + b) % Q;
      y = (((a + Q - b) % Q) * w) % Q;
      if (m == 2'd2) begin
        x = (x % 2 == 1) ? (x + Q) / 2 : x / 2;
        y = (y % 2 == 1) ? (y + Q) / 2 : y / 2;
      end
    end else begin
      t = (w * b) % Q;
      x = (a + t) % Q;
      y = (a + Q - t) % Q;
    end
    return {x[31:0], y[31:0]};
  endfunction

  task automatic run_vec(input string tag, input logic [1:0] m, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] w,
                         input logic [63:0] e1, input logic [63:0] e2);
    int lat;
    mode_i = m; data1_i = a; data2_i = b; zeta_i = w; in_valid_i = 1;
    @(posedge clk_i); #1 in_valid_i = 0;
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk_i); #1 lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_d1"}, data1_o, e1);
    check({tag, "_d2"}, data2_o, e2);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2 reset_ni = 0;
    #1 check("rst_v", {out_valid_o, busy_o}, 0);
    check("rst_d", {data1_o, data2_o}, 0);
    #19 reset_ni = 1;
    @(posedge clk_i); #1 check("rst_rdy", in_ready_o, 1);

    run_vec("ct", 2'd0, {32'd10, 32'd1}, {32'd4, 32'd2}, {32'd5, 32'd3},
            {32'd30, 32'd7}, {32'd8380407, 32'd8380412});
    run_vec("gs", 2'd1, {32'd3, 32'd5}, {32'd5, 32'd3}, {32'd2, 32'd10},
            {32'd8, 32'd8}, {32'd8380413, 32'd20});
    run_vec("gsh", 2'd2, {32'd3, 32'd5}, {32'd5, 32'd3}, {32'd2, 32'd10},
            {32'd4, 32'd4}, {32'd8380415, 32'd10});
    run_vec("gsh_odd", 2'd2, {32'd0, 32'd2}, {32'd0, 32'd1}, {32'd0, 32'd1},
            {32'd0, 32'd4190210}, {32'd0, 32'd4190209});
    run_vec("ct_wrap", 2'd0, {32'd0, 32'd8380416}, {32'd1, 32'd8380416}, {32'd8380416, 32'd1},
            {32'd8380416, 32'd8380415}, {32'd1, 32'd0});
    run_vec("rsvd", 2'd3, {32'd0, 32'd1}, {32'd1, 32'd2}, {32'd8380416, 32'd3},
            {32'd8380416, 32'd7}, {32'd1, 32'd8380412});
    run_vec("ct_big", 2'd0, {32'd7, 32'd0}, {32'd0, 32'd8380416}, {32'd0, 32'd8380416},
            {32'd7, 32'd1}, {32'd7, 32'd8380416});

    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [1:0] m;
          logic [63:0] a, b, w, g0, g1;
          m = 2'($urandom_range(3));
          a = {32'($urandom_range(32'(Q - 1))), 32'($urandom_range(32'(Q - 1)))};
          b = {32'($urandom_range(32'(Q - 1))), 32'($urandom_range(32'(Q - 1)))};
          w = {32'($urandom_range(32'(Q - 1))), 32'($urandom_range(32'(Q - 1)))};
          mode_i = m; data1_i = a; data2_i = b; zeta_i = w; in_valid_i = 1;
          @(negedge clk_i);
          for (int c = 0; c < 20 && !in_ready_o; c++) @(negedge clk_i);
          g0 = gold_lane(m, a[31:0], b[31:0], w[31:0]);
          g1 = gold_lane(m, a[63:32], b[63:32], w[63:32]);
          exq.push_back({g1[63:32], g0[63:32], g1[31:0], g0[31:0]});
          @(posedge clk_i); #1;
        end
        in_valid_i = 0;
      end
      begin
        repeat (6) @(posedge clk_i);
        #1 out_ready_i = 0;
        repeat (5) @(posedge clk_i);
        #1 out_ready_i = 1;
      end
      begin
        logic [127:0] prev, e;
        logic pst, stalled;
        pst = 0; prev = 0;
        for (int c = 0; c < 200 && got_n < 16; c++) begin
          @(negedge clk_i);
          if (pst) check("stall_hold", {data1_o, data2_o}, prev);
          stalled = out_valid_o && !out_ready_i;
          if (stalled) check("stall_rdy", in_ready_o, 0);
          if (out_valid_o && out_ready_i) begin
            e = exq.size() > 0 ? exq.pop_front() : '1;
            check("stream", {data1_o, data2_o}, e);
            got_n++;
          end
          pst = stalled;
          prev = {data1_o, data2_o};
        end
      end
    join
    check("stream_cnt", got_n, 16);
    check("stream_left", exq.size(), 0);
    @(posedge clk_i); #1 check("stream_drain", {out_valid_o, busy_o}, 0);

    mode_i = 0; data1_i = {32'd10, 32'd1}; data2_i = {32'd4, 32'd2}; zeta_i = {32'd5, 32'd3};
    in_valid_i = 1;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    in_valid_i = 0;
    check("pre_rst", {out_valid_o, busy_o}, 2'b11);
    #2 reset_ni = 0;
    #1 check("mid_rst_v", {out_valid_o, busy_o}, 0);
    check("mid_rst_d", {data1_o, data2_o}, 0);
    @(posedge clk_i); #3 reset_ni = 1;
    check("post_rst_rdy", in_ready_o, 1);
    @(posedge clk_i); #1 check("post_rst_idle", {out_valid_o, busy_o}, 0);
    run_vec("after_rst", 2'd1, {32'd3, 32'd5}, {32'd5, 32'd3}, {32'd2, 32'd10},
            {32'd8, 32'd8}, {32'd8380413, 32'd20});

    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("idle_v", {out_valid_o, busy_o}, 0);
      check("idle_d", {data1_o, data2_o}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
